// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_e;

    localparam int MUL_ITER  = 33;
    localparam int MUL_CNT_W = 6;

    // Radix-2 Booth recoding on (Q LSB, q_1).
    function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   booth_decode = BOOTH_ADD;
            2'b10:   booth_decode = BOOTH_SUB;
            default: booth_decode = BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Start/busy/done handshake and operand/result bus between the EX stage and the multiplier.
interface mult_seq_ctrl_if #(parameter int WIDTH = 32);

    logic             start;
    logic             is_signed;
    logic             kill;
    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] b;
    logic             busy;
    logic             done;
    logic [0:WIDTH-1] prod_hi;
    logic [0:WIDTH-1] prod_lo;

    modport master (
        output start, is_signed, kill, a, b,
        input  busy, done, prod_hi, prod_lo
    );

    modport slave (
        input  start, is_signed, kill, a, b,
        output busy, done, prod_hi, prod_lo
    );

endinterface

// File: rtl/fa_nbit.sv
// Big-endian ripple-carry adder (bit 0 = MSB), carry propagating from bit WIDTH-1 up to bit 0.
module fa_nbit #(
    parameter int WIDTH = 33
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             cin,
    output logic [0:WIDTH-1] sum,
    output logic             cout,
    output logic             of
);

    logic carry;
    logic carry_msb;

    always_comb begin
        sum       = '0;
        carry     = cin;
        carry_msb = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) carry_msb = carry;
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
        of   = carry ^ carry_msb;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential WIDTHxWIDTH radix-2 Booth multiplier: one shared adder, one iteration per RUN cycle.
module mult_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_seq_ctrl_if.slave bus
);

    localparam int XW = WIDTH + 1;

    mul_state_e        state, state_n;
    logic [0:XW-1]     acc, q, m;
    logic              q_1;
    logic [MUL_CNT_W-1:0] cnt;

    booth_op_e         op;
    logic [0:XW-1]     add_b;
    logic              add_cin;
    logic [0:XW-1]     sum;
    logic              add_cout, add_of;
    logic              add_flags_unused;

    logic [0:XW-1]     sh_acc, sh_q;
    logic [0:2*XW-1]   full;
    logic              last_iter;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    assign last_iter = (cnt == MUL_CNT_W'(1));

    // Next-state logic; kill overrides everything including a same-cycle start.
    always_comb begin
        state_n = state;
        if (bus.kill) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_n = RUN;
                RUN:     if (last_iter) state_n = DONE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs decode the state flops only, so no input reaches them combinationally.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // The adder runs every cycle; NOP iterations add zero.
    always_comb begin
        op = booth_decode(q[XW-1], q_1);
        case (op)
            BOOTH_ADD: add_b = m;
            BOOTH_SUB: add_b = ~m;
            default:   add_b = '0;
        endcase
        add_cin = (op == BOOTH_SUB);
    end

    fa_nbit #(.WIDTH(XW)) u_add (
        .a    (acc),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (add_cout),
        .of   (add_of)
    );

    // A 33-bit accumulator cannot overflow here, so the flags carry no information.
    assign add_flags_unused = add_cout ^ add_of;

    // Arithmetic right shift of {sum, Q, q_1}
    assign sh_acc = {sum[0], sum[0:XW-2]};
    assign sh_q   = {sum[XW-1], q[0:XW-2]};
    assign full   = {sh_acc, sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            q           <= '0;
            m           <= '0;
            q_1         <= 1'b0;
            cnt         <= '0;
            bus.prod_hi <= '0;
            bus.prod_lo <= '0;
        end else if (!bus.kill) begin
            if (state == IDLE && bus.start) begin
                acc <= '0;
                q_1 <= 1'b0;
                m   <= {bus.is_signed & bus.a[0], bus.a};
                q   <= {bus.is_signed & bus.b[0], bus.b};
                cnt <= MUL_CNT_W'(ITER);
            end else if (state == RUN) begin
                acc <= sh_acc;
                q   <= sh_q;
                q_1 <= q[XW-1];
                cnt <= cnt - MUL_CNT_W'(1);
                if (last_iter) begin
                    bus.prod_hi <= full[2:WIDTH+1];
                    bus.prod_lo <= full[WIDTH+2:2*WIDTH+1];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and random checks of mult_seq_ctrl against a plain-arithmetic product model.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_asrt = 0;
    int   n_fail = 0;
    logic [63:0] last_prod;

    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(32)) ifc ();

    mult_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            ref_mul = 64'(sx * sy);
        end else begin
            ref_mul = {32'b0, x} * {32'b0, y};
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
        ifc.start = 1'b1; ifc.a = x; ifc.b = y; ifc.is_signed = s;
        @(negedge clk);
        ifc.start = 1'b0; ifc.a = $urandom; ifc.b = $urandom; ifc.is_signed = $urandom;
    endtask

    task automatic finish_op(input int cyc0, output int cyc, output int bcnt);
        cyc = cyc0; bcnt = 0;
        while (!ifc.done && cyc < 100) begin
            if (ifc.busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic s, input logic [63:0] exp);
        int cyc, bc;
        issue(x, y, s);
        finish_op(1, cyc, bc);
        chk({tag, "_lat"}, 64'(cyc), 64'd34);
        chk({tag, "_busy"}, 64'(bc), 64'd33);
        chk({tag, "_prod"}, {ifc.prod_hi, ifc.prod_lo}, exp);
        last_prod = exp;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(ifc.done), 64'd0);
    endtask

    initial begin
        int cyc, bc;
        logic [31:0] x, y;
        logic s;
        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.kill = 1'b0; ifc.is_signed = 1'b0; ifc.a = '0; ifc.b = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_done", 64'(ifc.done), 64'd0);
        chk("rst_prod", {ifc.prod_hi, ifc.prod_lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_check("u3x5",  32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        run_check("umax",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_check("sm1x1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_check("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run_check("sm1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);

        // Second start mid-RUN must be ignored
        issue(32'd7, 32'd6, 1'b1);
        bc = 0;
        for (int k = 1; k < 10; k++) begin
            if (ifc.busy) bc++;
            @(negedge clk);
        end
        ifc.start = 1'b1; ifc.a = 32'd2; ifc.b = 32'd2; ifc.is_signed = 1'b1;
        if (ifc.busy) bc++;
        @(negedge clk);
        ifc.start = 1'b0;
        finish_op(11, cyc, x);
        chk("ign_lat", 64'(cyc), 64'd34);
        chk("ign_busy", 64'(bc + int'(x)), 64'd33);
        chk("ign_prod", {ifc.prod_hi, ifc.prod_lo}, 64'h2A);
        last_prod = 64'h2A;
        @(negedge clk);
        chk("ign_pulse", 64'(ifc.done), 64'd0);
        @(negedge clk);
        chk("ign_idle", 64'(ifc.busy), 64'd0);
        run_check("s2x2", 32'd2, 32'd2, 1'b1, 64'd4);

        // Kill at cycle 12 of a RUN
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        for (int k = 1; k < 12; k++) @(negedge clk);
        ifc.kill = 1'b1;
        @(negedge clk);
        ifc.kill = 1'b0;
        chk("kill_busy", 64'(ifc.busy), 64'd0);
        chk("kill_done", 64'(ifc.done), 64'd0);
        chk("kill_prod", {ifc.prod_hi, ifc.prod_lo}, last_prod);
        run_check("post_kill", 32'd11, 32'd13, 1'b0, 64'd143);

        // Kill together with start in IDLE
        ifc.kill = 1'b1;
        issue(32'd5, 32'd5, 1'b0);
        ifc.kill = 1'b0;
        chk("killst_busy", 64'(ifc.busy), 64'd0);

        // Asynchronous reset at cycle 20 of a RUN
        issue(32'hDEAD_BEEF, 32'h0000_1000, 1'b1);
        for (int k = 1; k < 20; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(ifc.busy), 64'd0);
        chk("arst_done", 64'(ifc.done), 64'd0);
        chk("arst_prod", {ifc.prod_hi, ifc.prod_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_check("u9x9", 32'd9, 32'd9, 1'b0, 64'h51);

        // Random operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            if (i % 6 == 0) x = 32'h8000_0000;
            if (i % 8 == 1) y = 32'hFFFF_FFFF;
            run_check("rand", x, y, s, ref_mul(x, y, s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential 32x32 multiplier controller for the EX stage. It computes a 64-bit product over 33 iterations of radix-2 Booth recoding, using one shared 33-bit ripple-carry adder instance. The pipeline drives it with a start/busy/done handshake and stalls on `busy`. It supports signed and unsigned operands, and the pipeline can abort it on a flush.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The product is 2*WIDTH bits.
- `ITER`, WIDTH+1: Booth iterations. This is fixed by the extension rule and must not be overridden.

Ports (all vectors `[0:N-1]`, bit 0 = MSB):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `is_signed` in 1: 1 = two's-complement operands, 0 = unsigned. Sampled with `start`.
- `kill` in 1: pipeline flush. Aborts any operation in progress.
- `a` in WIDTH: multiplicand. Sampled with `start`.
- `b` in WIDTH: multiplier. Sampled with `start`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when the product is valid.
- `prod_hi` out WIDTH: upper 32 bits of the product.
- `prod_lo` out WIDTH: lower 32 bits of the product.

## Operation
- **Operand extension to 33 bits.** If `is_signed`, sign-extend; otherwise zero-extend.
  - M = extended `a`. Q = extended `b`.
  - ACC (33 bits) = 0. q_1 = 0.
  - ITER = 33 makes the unsigned case exact with plain Booth recoding.
- **Each RUN cycle**, on (Q LSB, q_1):
  - 01: ACC ← ACC + M.
  - 10: ACC ← ACC − M. The adder takes B = ~M, cin = 1.
  - 00/11: ACC ← ACC + 0. The adder is still exercised.
- **After the add:** arithmetic right shift of {ACC, Q, q_1} by one. The ACC MSB is replicated.
- **Adder flags:** cout and of are ignored. A 33-bit ACC cannot overflow under this scheme.
- **Result:** after 33 iterations, {ACC, Q} is 66 bits. The product is the 64 LSBs.
  - `prod_hi` = {ACC,Q}[2:33].
  - `prod_lo` = {ACC,Q}[34:65].
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on `start` (and not `kill`). Operands are latched and the counter is loaded with 33.
  - RUN → RUN while count > 1. The count decrements each cycle.
  - RUN → DONE when the last iteration completes. `prod_hi`/`prod_lo` are registered from {ACC,Q} at that edge.
  - DONE → IDLE unconditionally after one cycle. `done` is high only in DONE.
- **`kill`:** in any state, `kill` forces IDLE on the next edge.
  - `prod_*` are left unchanged.
  - No `done` pulse is issued.
  - `kill` with `start` in IDLE is a kill; `start` is ignored.
- **`start` while not in IDLE:** ignored. No queueing.
- **Output holding:** `prod_hi`/`prod_lo` hold their last completed result until the next completion.

## Timing
- **Reset values:** state IDLE, `busy` 0, `done` 0, `prod_hi`/`prod_lo` 0, ACC/Q/M/q_1/count 0.
- **Asynchronous reset:** takes effect immediately, including mid-RUN. No `done` follows.
- **Latency:**
  - `start` high at edge T → `busy` high after T, through T+33.
  - `done` high for the cycle after edge T+33. The result is valid in that same cycle.
- **Throughput:** a new `start` is accepted in the cycle after DONE. There are 35 cycles between back-to-back accepted starts.
- **Combinational path:** one 33-bit ripple-carry add per cycle. This path is the block's critical path.
- **Registered outputs:** all outputs are registered. There is no combinational input-to-output path.

## Structure
- **Shared package `mul_pkg`:**
  - State encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - `MUL_ITER` = 33.
  - `MUL_CNT_W` = 6.
- **Sub-module:** one instance of the existing `fa_nbit`, with WIDTH = 33 and big-endian indexing. All adds and subtracts go through it.
- **Controller logic:** the FSM, counter, Booth select mux and shift registers live in `mult_seq_ctrl`.

## Test plan
- Unsigned `a`=3, `b`=5, `start` one cycle → `done` on cycle 34. `prod_hi`=0x00000000, `prod_lo`=0x0000000F. `busy` is high for exactly 33 cycles.
- Unsigned `a`=`b`=0xFFFFFFFF → `prod_hi`=0xFFFFFFFE, `prod_lo`=0x00000001.
- Signed:
  - 0xFFFFFFFF × 0x00000001 → 0xFFFFFFFF_FFFFFFFF.
  - 0x80000000 × 0x80000000 → 0x40000000_00000000.
  - 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000_00000001.
- `start` with 7×6 signed. Pulse `start` again with 2×2 at cycle 10 → ignored. Result is 0x2A with one `done`. A subsequent 2×2 gives 4.
- `kill` at cycle 12 of a RUN → IDLE next cycle. No `done`. `prod_*` keep the previous result. A new `start` is accepted immediately.
- `rst_n` low at cycle 20 of a RUN → all outputs 0 asynchronously. After release, 9×9 unsigned → 0x51.
